// File: rtl/hamming_scrub_counter_if.sv
// Bus bundle for hamming_scrub_counter: count control, corrected readout,
// scrub status/log and fault-injection strobe.
interface hamming_scrub_counter_if #(
   parameter int unsigned WIDTH    = 32,
   parameter int unsigned ERRCNT_W = 8
);
   localparam int unsigned BLOCKS   = WIDTH / 4;
   localparam int unsigned PAR_BITS = BLOCKS * 3;

   logic                enable;
   logic                load;
   logic [WIDTH-1:0]    load_value;
   logic [WIDTH-1:0]    counter;
   logic [PAR_BITS-1:0] parity;
   logic [PAR_BITS-1:0] syndrome;
   logic                scrub_busy;
   logic [ERRCNT_W-1:0] err_count;
   logic [BLOCKS-1:0]   err_block_mask;
   logic                err_clr;
   logic                inj_valid;
   logic [WIDTH-1:0]    inj_data_mask;
   logic [PAR_BITS-1:0] inj_par_mask;

   // Driver side: controls the counter and observes its state
   modport master (
      output enable, load, load_value, err_clr,
             inj_valid, inj_data_mask, inj_par_mask,
      input  counter, parity, syndrome, scrub_busy,
             err_count, err_block_mask
   );

   // Counter side
   modport slave (
      input  enable, load, load_value, err_clr,
             inj_valid, inj_data_mask, inj_par_mask,
      output counter, parity, syndrome, scrub_busy,
             err_count, err_block_mask
   );
endinterface

// File: rtl/hamming_scrub_counter.sv
// SEU-hardened up-counter. The count is stored as 4-bit blocks, each guarded
// by Hamming(7,4) parity; readout is single-error corrected combinationally and
// a background scrub pass writes corrected data back while counting is paused.
// Optional feature macro: HAMMING_FAULT_INJ_EN enables the XOR fault-injection
// path on the stored word; without it the inj_* signals are ignored.
module hamming_scrub_counter #(
   parameter int unsigned WIDTH          = 32,
   parameter int unsigned SCRUB_INTERVAL = 16,
   parameter int unsigned ERRCNT_W       = 8
) (
   input logic                   clk,
   input logic                   rst,
   hamming_scrub_counter_if.slave bus
);
   localparam int unsigned BLOCKS   = WIDTH / 4;
   localparam int unsigned PAR_BITS = BLOCKS * 3;
   localparam int unsigned TIMER_W  = (SCRUB_INTERVAL > 1) ? $clog2(SCRUB_INTERVAL) : 1;
   localparam logic [TIMER_W-1:0] TIMER_LAST = TIMER_W'(SCRUB_INTERVAL - 1);

   // Elaboration guards on configuration
   generate
      if ((WIDTH % 4) != 0 || WIDTH == 0) begin : g_bad_width
         $error("hamming_scrub_counter: WIDTH must be a non-zero multiple of 4");
      end
      if (SCRUB_INTERVAL < 1) begin : g_bad_interval
         $error("hamming_scrub_counter: SCRUB_INTERVAL must be >= 1");
      end
   endgenerate

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      CHECK = 2'd1,
      FIX   = 2'd2
   } state_t;

   // Parity of one 4-bit block: {p2,p1,p0}
   function automatic logic [2:0] enc_nib(input logic [3:0] d);
      logic [2:0] p;
      p[0] = d[0] ^ d[1] ^ d[2];
      p[1] = d[0] ^ d[1] ^ d[3];
      p[2] = d[0] ^ d[2] ^ d[3];
      return p;
   endfunction

   // Parity of the whole word, block by block
   function automatic logic [PAR_BITS-1:0] enc_word(input logic [WIDTH-1:0] d);
      logic [PAR_BITS-1:0] p;
      p = '0;
      for (int b = 0; b < BLOCKS; b++) begin
         p[3*b +: 3] = enc_nib(d[4*b +: 4]);
      end
      return p;
   endfunction

   // Data-bit flip pattern implied by a block syndrome
   function automatic logic [3:0] syn_flip(input logic [2:0] s);
      logic [3:0] f;
      case (s)
         3'b111:  f = 4'b0001;
         3'b011:  f = 4'b0010;
         3'b101:  f = 4'b0100;
         3'b110:  f = 4'b1000;
         default: f = 4'b0000;
      endcase
      return f;
   endfunction

   // Stored word and scrub state
   logic [WIDTH-1:0]    data_q;
   logic [PAR_BITS-1:0] par_q;
   state_t              state_q;
   logic [TIMER_W-1:0]  timer_q;
   logic [PAR_BITS-1:0] syn_q;
   logic [WIDTH-1:0]    fix_word_q;
   logic                busy_q;
   logic [ERRCNT_W-1:0] err_count_q;
   logic [BLOCKS-1:0]   err_mask_q;

   logic [PAR_BITS-1:0] syndrome_c;
   logic [WIDTH-1:0]    decoded_c;
   logic [WIDTH-1:0]    incr_c;
   logic [BLOCKS-1:0]   syn_q_blocks_c;
   logic                fix_commit_c;

   // Live syndrome and single-error-corrected readout
   always_comb begin
      syndrome_c = par_q ^ enc_word(data_q);
      decoded_c  = data_q;
      for (int b = 0; b < BLOCKS; b++) begin
         decoded_c[4*b +: 4] = data_q[4*b +: 4] ^ syn_flip(syndrome_c[3*b +: 3]);
      end
   end

   // Per-block flags from the registered CHECK syndrome
   always_comb begin
      syn_q_blocks_c = '0;
      for (int b = 0; b < BLOCKS; b++) begin
         syn_q_blocks_c[b] = |syn_q[3*b +: 3];
      end
   end

   // Increment from the corrected value; FIX only lands when no count write pre-empts it
   always_comb begin
      incr_c       = decoded_c + WIDTH'(1);
      fix_commit_c = (state_q == FIX) && !bus.load && !bus.enable;
   end

   // Counter storage, scrub FSM and correction log
   always_ff @(posedge clk) begin
      if (rst) begin
         data_q      <= '0;
         par_q       <= '0;
         state_q     <= IDLE;
         timer_q     <= '0;
         syn_q       <= '0;
         fix_word_q  <= '0;
         busy_q      <= 1'b0;
         err_count_q <= '0;
         err_mask_q  <= '0;
      end else begin
         // Log: clear beats a same-cycle FIX update
         if (bus.err_clr) begin
            err_count_q <= '0;
            err_mask_q  <= '0;
         end else if (fix_commit_c) begin
            if (err_count_q != {ERRCNT_W{1'b1}}) begin
               err_count_q <= err_count_q + ERRCNT_W'(1);
            end
            err_mask_q <= err_mask_q | syn_q_blocks_c;
         end

         if (bus.load) begin
            data_q  <= bus.load_value;
            par_q   <= enc_word(bus.load_value);
            state_q <= IDLE;
            timer_q <= '0;
            busy_q  <= 1'b0;
         end else if (bus.enable) begin
            data_q  <= incr_c;
            par_q   <= enc_word(incr_c);
            state_q <= IDLE;
            timer_q <= '0;
            busy_q  <= 1'b0;
         end else begin
            case (state_q)
               IDLE: begin
                  if (timer_q == TIMER_LAST) begin
                     state_q <= CHECK;
                     timer_q <= '0;
                     busy_q  <= 1'b1;
                  end else begin
                     timer_q <= timer_q + TIMER_W'(1);
                  end
               end
               CHECK: begin
                  syn_q      <= syndrome_c;
                  fix_word_q <= decoded_c;
                  if (syndrome_c != '0) begin
                     state_q <= FIX;
                     busy_q  <= 1'b1;
                  end else begin
                     state_q <= IDLE;
                     busy_q  <= 1'b0;
                  end
               end
               FIX: begin
                  data_q  <= fix_word_q;
                  par_q   <= enc_word(fix_word_q);
                  state_q <= IDLE;
                  busy_q  <= 1'b0;
               end
               default: begin
                  state_q <= IDLE;
                  timer_q <= '0;
                  busy_q  <= 1'b0;
               end
            endcase

`ifdef HAMMING_FAULT_INJ_EN
            // Injection is the lowest-priority write; a FIX writeback drops it
            if (bus.inj_valid && state_q != FIX) begin
               data_q <= data_q ^ bus.inj_data_mask;
               par_q  <= par_q ^ bus.inj_par_mask;
            end
`endif
         end
      end
   end

`ifndef HAMMING_FAULT_INJ_EN
   // Injection inputs are intentionally ignored in this build
   logic inj_unused;
   assign inj_unused = ^{bus.inj_valid, bus.inj_data_mask, bus.inj_par_mask};
`endif

   // Outputs
   assign bus.counter        = decoded_c;
   assign bus.parity         = par_q;
   assign bus.syndrome       = syndrome_c;
   assign bus.scrub_busy     = busy_q;
   assign bus.err_count      = err_count_q;
   assign bus.err_block_mask = err_mask_q;
endmodule

// File: tb/tb_hamming_scrub_counter.sv
// Directed bench for hamming_scrub_counter: table of count/load vectors,
// then hand-written scrub, log-clear and abort sequences.
module tb_hamming_scrub_counter;
   localparam int unsigned WIDTH    = 32;
   localparam int unsigned INTERVAL = 16;
   localparam int unsigned ERRCNT_W = 8;
   localparam int unsigned WAIT_MAX = INTERVAL + 4;

   logic clk;
   logic rst;
   int   checks;
   int   errors;

   hamming_scrub_counter_if #(.WIDTH(WIDTH), .ERRCNT_W(ERRCNT_W)) bus ();

   hamming_scrub_counter #(
      .WIDTH(WIDTH),
      .SCRUB_INTERVAL(INTERVAL),
      .ERRCNT_W(ERRCNT_W)
   ) dut (
      .clk(clk),
      .rst(rst),
      .bus(bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic        rst;
      logic        load;
      logic [31:0] load_value;
      logic        enable;
      logic [31:0] exp_counter;
   } vec_t;

   vec_t tbl[12];

   // Hand-tabulated Hamming(7,4) parity {p2,p1,p0} per nibble value
   function automatic logic [2:0] nib_par(input logic [3:0] n);
      case (n)
         4'h0: return 3'd0;  4'h1: return 3'd7;  4'h2: return 3'd3;  4'h3: return 3'd4;
         4'h4: return 3'd5;  4'h5: return 3'd2;  4'h6: return 3'd6;  4'h7: return 3'd1;
         4'h8: return 3'd6;  4'h9: return 3'd1;  4'hA: return 3'd5;  4'hB: return 3'd2;
         4'hC: return 3'd3;  4'hD: return 3'd4;  4'hE: return 3'd0;  default: return 3'd7;
      endcase
   endfunction

   function automatic logic [23:0] par_of(input logic [31:0] w);
      logic [23:0] p;
      for (int i = 0; i < 8; i++) p[3*i +: 3] = nib_par(w[4*i +: 4]);
      return p;
   endfunction

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic inject(input logic [31:0] dm, input logic [23:0] pm);
      bus.inj_valid     = 1'b1;
      bus.inj_data_mask = dm;
      bus.inj_par_mask  = pm;
      step();
      bus.inj_valid     = 1'b0;
      bus.inj_data_mask = '0;
      bus.inj_par_mask  = '0;
   endtask

   // Idle until err_count reaches target; also report whether busy was seen
   task automatic wait_err(input logic [7:0] target, output logic saw_busy);
      saw_busy = 1'b0;
      for (int i = 0; i < WAIT_MAX; i++) begin
         step();
         if (bus.scrub_busy) saw_busy = 1'b1;
         if (bus.err_count == target) break;
      end
      check("scrub_err_count", 64'(bus.err_count), 64'(target));
   endtask

   // Idle until the scrub FSM enters CHECK (busy first rises)
   task automatic wait_busy();
      for (int i = 0; i < WAIT_MAX; i++) begin
         step();
         if (bus.scrub_busy) break;
      end
      check("wait_busy", 64'(bus.scrub_busy), 64'd1);
   endtask

   logic        saw;
   logic [31:0] tmp;

   initial begin
      checks = 0;
      errors = 0;
      tbl[0]  = '{1'b1, 1'b0, 32'h0,         1'b0, 32'h0};
      tbl[1]  = '{1'b0, 1'b0, 32'h0,         1'b1, 32'h1};
      tbl[2]  = '{1'b0, 1'b0, 32'h0,         1'b1, 32'h2};
      tbl[3]  = '{1'b0, 1'b0, 32'h0,         1'b1, 32'h3};
      tbl[4]  = '{1'b0, 1'b0, 32'h0,         1'b1, 32'h4};
      tbl[5]  = '{1'b0, 1'b0, 32'h0,         1'b1, 32'h5};
      tbl[6]  = '{1'b0, 1'b1, 32'hFFFF_FFFF, 1'b0, 32'hFFFF_FFFF};
      tbl[7]  = '{1'b0, 1'b0, 32'h0,         1'b1, 32'h0};
      tbl[8]  = '{1'b0, 1'b1, 32'h0000_00A5, 1'b0, 32'h0000_00A5};
      tbl[9]  = '{1'b0, 1'b1, 32'h0000_0010, 1'b1, 32'h0000_0010};
      tbl[10] = '{1'b0, 1'b0, 32'h0,         1'b1, 32'h0000_0011};
      tbl[11] = '{1'b0, 1'b1, 32'h1234_5678, 1'b1, 32'h1234_5678};

      rst = 1'b1;
      bus.enable = 1'b0; bus.load = 1'b0; bus.load_value = '0; bus.err_clr = 1'b0;
      bus.inj_valid = 1'b0; bus.inj_data_mask = '0; bus.inj_par_mask = '0;
      step();
      step();
      check("rst_counter",  64'(bus.counter), 64'd0);
      check("rst_parity",   64'(bus.parity), 64'd0);
      check("rst_syndrome", 64'(bus.syndrome), 64'd0);
      check("rst_busy",     64'(bus.scrub_busy), 64'd0);
      check("rst_errcnt",   64'(bus.err_count), 64'd0);
      check("rst_mask",     64'(bus.err_block_mask), 64'd0);

      // Counting, load priority and wrap
      for (int i = 0; i < 12; i++) begin
         rst = tbl[i].rst;
         bus.load = tbl[i].load;
         bus.load_value = tbl[i].load_value;
         bus.enable = tbl[i].enable;
         step();
         check($sformatf("vec%0d_counter", i), 64'(bus.counter), 64'(tbl[i].exp_counter));
         check($sformatf("vec%0d_parity", i), 64'(bus.parity), 64'(par_of(tbl[i].exp_counter)));
         check($sformatf("vec%0d_syndrome", i), 64'(bus.syndrome), 64'd0);
         check($sformatf("vec%0d_errcnt", i), 64'(bus.err_count), 64'd0);
      end
      rst = 1'b0; bus.enable = 1'b0;

      // Single data error in block 1, scrubbed back
      bus.load = 1'b1; bus.load_value = 32'h0000_00A5;
      step();
      bus.load = 1'b0;
      inject(32'h0000_0020, 24'h0);
      check("t3_counter", 64'(bus.counter), 64'h0000_00A5);
`ifdef HAMMING_FAULT_INJ_EN
      tmp = 32'(bus.syndrome);
      check("t3_syn_blk1", 64'(tmp[5:3]), 64'd3);
      wait_err(8'd1, saw);
      check("t3_saw_busy", 64'(saw), 64'd1);
      check("t3_syndrome", 64'(bus.syndrome), 64'd0);
      check("t3_parity",   64'(bus.parity), 64'(par_of(32'h0000_00A5)));
      check("t3_mask",     64'(bus.err_block_mask), 64'h02);
      check("t3_counter2", 64'(bus.counter), 64'h0000_00A5);

      // Parity-only error in block 0
      inject(32'h0, 24'h000001);
      check("t4_counter", 64'(bus.counter), 64'h0000_00A5);
      check("t4_syndrome", 64'(bus.syndrome), 64'd1);
      wait_err(8'd2, saw);
      check("t4_parity", 64'(bus.parity), 64'(par_of(32'h0000_00A5)));
      check("t4_mask",   64'(bus.err_block_mask), 64'h03);

      // Clear, then errors in blocks 0 and 7 fixed by one writeback
      bus.err_clr = 1'b1;
      step();
      bus.err_clr = 1'b0;
      check("t5_clr_cnt",  64'(bus.err_count), 64'd0);
      check("t5_clr_mask", 64'(bus.err_block_mask), 64'd0);
      inject(32'h1000_0001, 24'h0);
      check("t5_syndrome", 64'(bus.syndrome), 64'hE00007);
      check("t5_counter",  64'(bus.counter), 64'h0000_00A5);
      wait_err(8'd1, saw);
      for (int i = 0; i < 3; i++) step();
      check("t5_errcnt", 64'(bus.err_count), 64'd1);
      check("t5_mask",   64'(bus.err_block_mask), 64'h81);
      check("t5_syn0",   64'(bus.syndrome), 64'd0);
      bus.err_clr = 1'b1;
      step();
      bus.err_clr = 1'b0;
      check("t5_clr2_cnt",  64'(bus.err_count), 64'd0);
      check("t5_clr2_mask", 64'(bus.err_block_mask), 64'd0);

      // err_clr in the FIX cycle wins over the log update
      inject(32'h0000_0400, 24'h0);
      wait_busy();
      step();
      check("clrfix_busy", 64'(bus.scrub_busy), 64'd1);
      bus.err_clr = 1'b1;
      step();
      bus.err_clr = 1'b0;
      check("clrfix_cnt",  64'(bus.err_count), 64'd0);
      check("clrfix_mask", 64'(bus.err_block_mask), 64'd0);
      check("clrfix_syn",  64'(bus.syndrome), 64'd0);
      check("clrfix_counter", 64'(bus.counter), 64'h0000_00A5);
`else
      check("t3_syn_noinj", 64'(bus.syndrome), 64'd0);
      for (int i = 0; i < WAIT_MAX; i++) step();
      check("t3_errcnt_noinj", 64'(bus.err_count), 64'd0);
      check("t3_counter_noinj", 64'(bus.counter), 64'h0000_00A5);
      check("t3_parity_noinj", 64'(bus.parity), 64'(par_of(32'h0000_00A5)));
`endif

      // Enable during CHECK aborts the scrub; increment uses the corrected value
      inject(32'h0000_0020, 24'h0);
      wait_busy();
      bus.enable = 1'b1;
      step();
      bus.enable = 1'b0;
      check("t6_counter", 64'(bus.counter), 64'h0000_00A6);
      check("t6_syndrome", 64'(bus.syndrome), 64'd0);
      check("t6_parity", 64'(bus.parity), 64'(par_of(32'h0000_00A6)));
      check("t6_busy", 64'(bus.scrub_busy), 64'd0);
      check("t6_errcnt", 64'(bus.err_count), 64'd0);

      // Synchronous reset clears everything mid-run
      rst = 1'b1;
      step();
      rst = 1'b0;
      check("rst2_counter", 64'(bus.counter), 64'd0);
      check("rst2_busy", 64'(bus.scrub_busy), 64'd0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
